bus_destination_regfile: RTL and testbench

BUS_DESTINATION_REGFILE -- requirements
Module: bus_destination_regfile

---
 rtl/cpu_bus_pkg.sv | 24 ++
 rtl/bus_destination_regfile_reg32.sv | 14 +
 rtl/bus_destination_regfile.sv | 79 +++++++
 tb/tb_bus_destination_regfile.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: bus source/destination code map shared by both ends of the CPU bus
package cpu_bus_pkg;
  localparam int NUM_GPR = 16;
  typedef enum logic [4:0] {
    CODE_NONE  = 5'd0,
    CODE_R0    = 5'd1,
    CODE_R15   = 5'd16,
    CODE_HI    = 5'd17,
    CODE_LO    = 5'd18,
    CODE_ZHI   = 5'd19,
    CODE_ZLO   = 5'd20,
    CODE_PC    = 5'd21,
    CODE_MDR   = 5'd22,
    CODE_INPORT = 5'd23,
    CODE_CSIGN = 5'd24,
    CODE_Y     = 5'd25,
    CODE_IR    = 5'd26,
    CODE_MAR   = 5'd27
  } bus_code_e;
  function automatic logic is_writable(input logic [4:0] c);
    return (c >= CODE_R0 && c <= CODE_R15) ||
           (c inside {CODE_HI, CODE_LO, CODE_PC, CODE_MDR, CODE_Y, CODE_IR, CODE_MAR});
  endfunction
endpackage

// File: rtl/bus_destination_regfile_reg32.sv
// reg32: register with synchronous active-low clear and load enable
module reg32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // clear wins over load; otherwise hold unless loaded
  always_ff @(posedge clk)
    q <= !clr_n ? '0 : ld ? d : q;
endmodule

// File: rtl/bus_destination_regfile.sv
// bus_destination_regfile: bus-written register file with one-hot destination decode
module bus_destination_regfile
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] BusMuxOut,
  input  logic [4:0]  dest_select,
  input  logic        dest_we,
  output logic [31:0] BusMuxIn_R0,
  output logic [31:0] BusMuxIn_R1,
  output logic [31:0] BusMuxIn_R2,
  output logic [31:0] BusMuxIn_R3,
  output logic [31:0] BusMuxIn_R4,
  output logic [31:0] BusMuxIn_R5,
  output logic [31:0] BusMuxIn_R6,
  output logic [31:0] BusMuxIn_R7,
  output logic [31:0] BusMuxIn_R8,
  output logic [31:0] BusMuxIn_R9,
  output logic [31:0] BusMuxIn_R10,
  output logic [31:0] BusMuxIn_R11,
  output logic [31:0] BusMuxIn_R12,
  output logic [31:0] BusMuxIn_R13,
  output logic [31:0] BusMuxIn_R14,
  output logic [31:0] BusMuxIn_R15,
  output logic [31:0] BusMuxIn_HI,
  output logic [31:0] BusMuxIn_LO,
  output logic [31:0] BusMuxIn_PC,
  output logic [31:0] BusMuxIn_MDR,
  output logic [31:0] BusMuxIn_Y,
  output logic [31:0] BusMuxIn_IR,
  output logic [8:0]  BusMuxIn_MAR,
  output logic        illegal_dest,
  output logic        err_sticky,
  output logic [4:0]  last_dest
);
  logic        wr;
  logic        bad;
  logic [31:0] r [NUM_GPR];
  // a write is accepted only for a writable code; anything else is flagged
  always_comb begin
    wr  = dest_we && is_writable(dest_select);
    bad = dest_we && !is_writable(dest_select);
  end
  for (genvar g = 0; g < NUM_GPR; g++) begin : gpr
    reg32 u_r (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == 5'(int'(CODE_R0) + g)),
               .d(BusMuxOut), .q(r[g]));
  end
  reg32 u_hi  (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_HI),  .d(BusMuxOut), .q(BusMuxIn_HI));
  reg32 u_lo  (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_LO),  .d(BusMuxOut), .q(BusMuxIn_LO));
  reg32 u_pc  (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_PC),  .d(BusMuxOut), .q(BusMuxIn_PC));
  reg32 u_mdr (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_MDR), .d(BusMuxOut), .q(BusMuxIn_MDR));
  reg32 u_y   (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_Y),   .d(BusMuxOut), .q(BusMuxIn_Y));
  reg32 u_ir  (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_IR),  .d(BusMuxOut), .q(BusMuxIn_IR));
  reg32 #(.W(9)) u_mar (.clk(clk), .clr_n(clr_n), .ld(wr && dest_select == CODE_MAR),
                        .d(BusMuxOut[8:0]), .q(BusMuxIn_MAR));
  assign BusMuxIn_R0  = r[0];
  assign BusMuxIn_R1  = r[1];
  assign BusMuxIn_R2  = r[2];
  assign BusMuxIn_R3  = r[3];
  assign BusMuxIn_R4  = r[4];
  assign BusMuxIn_R5  = r[5];
  assign BusMuxIn_R6  = r[6];
  assign BusMuxIn_R7  = r[7];
  assign BusMuxIn_R8  = r[8];
  assign BusMuxIn_R9  = r[9];
  assign BusMuxIn_R10 = r[10];
  assign BusMuxIn_R11 = r[11];
  assign BusMuxIn_R12 = r[12];
  assign BusMuxIn_R13 = r[13];
  assign BusMuxIn_R14 = r[14];
  assign BusMuxIn_R15 = r[15];
  // status: one-cycle illegal pulse, sticky error, code of last accepted write
  always_ff @(posedge clk) begin
    illegal_dest <= clr_n && bad;
    err_sticky   <= clr_n && (err_sticky || bad);
    last_dest    <= !clr_n ? 5'd0 : wr ? dest_select : last_dest;
  end
endmodule

// File: tb/tb_bus_destination_regfile.sv
// tb_bus_destination_regfile: randomized + directed check against a code-indexed memory model
module tb_bus_destination_regfile;
  logic        clk = 0;
  logic        clr_n = 0;
  logic [31:0] BusMuxOut = 0;
  logic [4:0]  dest_select = 0;
  logic        dest_we = 0;
  logic [31:0] r_out [16];
  logic [31:0] hi, lo, pc, mdr, y, ir;
  logic [8:0]  mar;
  logic        illegal_dest, err_sticky;
  logic [4:0]  last_dest;
  logic [31:0] m [32];
  logic        m_ill, m_err;
  logic [4:0]  m_last;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  bus_destination_regfile dut (
    .clk(clk), .clr_n(clr_n), .BusMuxOut(BusMuxOut), .dest_select(dest_select), .dest_we(dest_we),
    .BusMuxIn_R0(r_out[0]), .BusMuxIn_R1(r_out[1]), .BusMuxIn_R2(r_out[2]), .BusMuxIn_R3(r_out[3]),
    .BusMuxIn_R4(r_out[4]), .BusMuxIn_R5(r_out[5]), .BusMuxIn_R6(r_out[6]), .BusMuxIn_R7(r_out[7]),
    .BusMuxIn_R8(r_out[8]), .BusMuxIn_R9(r_out[9]), .BusMuxIn_R10(r_out[10]), .BusMuxIn_R11(r_out[11]),
    .BusMuxIn_R12(r_out[12]), .BusMuxIn_R13(r_out[13]), .BusMuxIn_R14(r_out[14]), .BusMuxIn_R15(r_out[15]),
    .BusMuxIn_HI(hi), .BusMuxIn_LO(lo), .BusMuxIn_PC(pc), .BusMuxIn_MDR(mdr), .BusMuxIn_Y(y),
    .BusMuxIn_IR(ir), .BusMuxIn_MAR(mar), .illegal_dest(illegal_dest), .err_sticky(err_sticky),
    .last_dest(last_dest)
  );

  function automatic bit writable(input int c);
    return (c >= 1 && c <= 16) || c == 17 || c == 18 || c == 21 || c == 22 || c == 25 || c == 26 || c == 27;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic drive(input logic rn, input logic we, input logic [4:0] c, input logic [31:0] d);
    clr_n = rn;
    dest_we = we;
    dest_select = c;
    BusMuxOut = d;
  endtask

  task automatic model_edge();
    if (!clr_n) begin
      for (int i = 0; i < 32; i++) m[i] = 0;
      m_ill = 0;
      m_err = 0;
      m_last = 0;
    end else if (dest_we && writable(int'(dest_select))) begin
      m[dest_select] = dest_select == 5'd27 ? (BusMuxOut & 32'h1ff) : BusMuxOut;
      m_last = dest_select;
      m_ill = 0;
    end else begin
      m_ill = dest_we;
      m_err = m_err | dest_we;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", tag, i), r_out[i], m[i+1]);
    chk({tag, "_hi"}, hi, m[17]);
    chk({tag, "_lo"}, lo, m[18]);
    chk({tag, "_pc"}, pc, m[21]);
    chk({tag, "_mdr"}, mdr, m[22]);
    chk({tag, "_y"}, y, m[25]);
    chk({tag, "_ir"}, ir, m[26]);
    chk({tag, "_mar"}, {23'd0, mar}, m[27]);
    chk({tag, "_ill"}, {31'd0, illegal_dest}, {31'd0, m_ill});
    chk({tag, "_err"}, {31'd0, err_sticky}, {31'd0, m_err});
    chk({tag, "_last"}, {27'd0, last_dest}, {27'd0, m_last});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 0;
    m_ill = 0;
    m_err = 0;
    m_last = 0;
    drive(0, 0, 0, 0);
    step();
    step();
    check_all("reset");
    drive(1, 1, 5'd5, 32'hDEADBEEF);
    step();
    chk("r4_deadbeef", r_out[4], 32'hDEADBEEF);
    chk("last5", {27'd0, last_dest}, 32'd5);
    check_all("wr5");
    drive(1, 1, 5'd27, 32'hFFFFFFFF);
    step();
    chk("mar_1ff", {23'd0, mar}, 32'h1ff);
    check_all("wr27");
    drive(1, 1, 5'd20, 32'h12345678);
    step();
    chk("ill20", {31'd0, illegal_dest}, 32'd1);
    chk("err20", {31'd0, err_sticky}, 32'd1);
    chk("last_kept", {27'd0, last_dest}, 32'd27);
    check_all("wr20");
    drive(1, 0, 5'd20, 32'h12345678);
    step();
    chk("ill_clear", {31'd0, illegal_dest}, 32'd0);
    chk("err_held", {31'd0, err_sticky}, 32'd1);
    check_all("idle");
    drive(1, 1, 5'd1, 32'hA);
    step();
    chk("r0_a", r_out[0], 32'hA);
    drive(1, 1, 5'd1, 32'hB);
    step();
    chk("r0_b", r_out[0], 32'hB);
    check_all("b2b");
    clr_n = 0;
    #2;
    clr_n = 1;
    drive(1, 0, 5'd0, 32'h0);
    step();
    chk("async_r0", r_out[0], 32'hB);
    check_all("async");
    drive(0, 1, 5'd17, 32'hCAFEF00D);
    step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    check_all("rstwr");
    for (int c = 0; c < 32; c++) begin
      drive(1, 1, 5'(c), 32'(c));
      step();
      chk($sformatf("sweep_ill%0d", c), {31'd0, illegal_dest}, {31'd0, !writable(c)});
      check_all($sformatf("sweep%0d", c));
    end
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      step();
      check_all("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
